// File: rtl/hamming_decode_scheduler.sv
// Two-channel Hamming(7,4) decoder sharing one datapath. A four-state FSM
// grants one requester at a time, decodes the captured codeword and holds
// the result on a valid/ready output. Saturating per-channel error counters
// track how often each link delivers a nonzero syndrome.
module hamming_decode_scheduler #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned FAIR  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [6:0]       req0_code,
    input  logic             req0_odd,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [6:0]       req1_code,
    input  logic             req1_odd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic             out_chan,
    output logic [2:0]       out_syndrome,
    output logic             out_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] err_cnt0,
    output logic [CNT_W-1:0] err_cnt1
);

    typedef enum logic [1:0] {StIdle, StCapture, StDecode, StOut} state_e;

    state_e           state_q, state_d;
    logic             win_q, win_d;    // channel currently being served
    logic             rr_q, rr_d;      // channel favoured on the next contested grant
    logic [6:0]       code_q, code_d;
    logic             odd_q, odd_d;
    logic [3:0]       data_q;
    logic             chan_q;
    logic [2:0]       syn_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    logic             load_out;
    logic             win_valid;
    logic             s1, s2, s3;
    logic [2:0]       syn_c;
    logic [3:0]       data_c;

    // Syndrome and single-bit correction on the captured codeword
    always_comb begin
        s1     = code_q[0] ^ code_q[2] ^ code_q[4] ^ code_q[6];
        s2     = code_q[1] ^ code_q[2] ^ code_q[5] ^ code_q[6];
        s3     = code_q[3] ^ code_q[4] ^ code_q[5] ^ code_q[6];
        syn_c  = odd_q ? ~{s3, s2, s1} : {s3, s2, s1};
        data_c = {code_q[6], code_q[5], code_q[4], code_q[2]};
        // Syndromes 1/2/4 point at parity bits, so data passes unchanged
        unique case (syn_c)
            3'd3:    data_c[0] = ~data_c[0];
            3'd5:    data_c[1] = ~data_c[1];
            3'd6:    data_c[2] = ~data_c[2];
            3'd7:    data_c[3] = ~data_c[3];
            default: data_c = data_c;
        endcase
    end

    // Arbitration, capture handshake and transaction sequencing
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        rr_d       = rr_q;
        code_d     = code_q;
        odd_d      = odd_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        load_out   = 1'b0;
        win_valid  = win_q ? req1_valid : req0_valid;
        unique case (state_q)
            StIdle: begin
                if (req0_valid || req1_valid) begin
                    if (req0_valid && req1_valid) begin
                        win_d = (FAIR != 0) ? rr_q : 1'b0;
                    end else begin
                        win_d = req1_valid;
                    end
                    state_d = StCapture;
                end
            end
            StCapture: begin
                req0_ready = ~win_q;
                req1_ready = win_q;
                // A winner that dropped valid forfeits the slot; pointer untouched
                if (win_valid) begin
                    code_d  = win_q ? req1_code : req0_code;
                    odd_d   = win_q ? req1_odd : req0_odd;
                    rr_d    = ~win_q;
                    state_d = StDecode;
                end else begin
                    state_d = StIdle;
                end
            end
            StDecode: begin
                load_out = 1'b1;
                state_d  = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Saturating error counters; clear wins over a same-cycle increment
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (cnt_clr) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else if (load_out && (syn_c != 3'd0)) begin
            if (!win_q && (cnt0_q != {CNT_W{1'b1}})) begin
                cnt0_d = cnt0_q + CNT_W'(1);
            end
            if (win_q && (cnt1_q != {CNT_W{1'b1}})) begin
                cnt1_d = cnt1_q + CNT_W'(1);
            end
        end
    end

    // State, capture and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            win_q   <= 1'b0;
            rr_q    <= 1'b0;
            code_q  <= '0;
            odd_q   <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            rr_q    <= rr_d;
            code_q  <= code_d;
            odd_q   <= odd_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    // Result registers, loaded once per transaction on leaving DECODE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            chan_q <= 1'b0;
            syn_q  <= '0;
            err_q  <= 1'b0;
        end else if (load_out) begin
            data_q <= data_c;
            chan_q <= win_q;
            syn_q  <= syn_c;
            err_q  <= (syn_c != 3'd0);
        end
    end

    assign out_valid    = (state_q == StOut);
    assign out_data     = data_q;
    assign out_chan     = chan_q;
    assign out_syndrome = syn_q;
    assign out_err      = err_q;
    assign err_cnt0     = cnt0_q;
    assign err_cnt1     = cnt1_q;

endmodule

// File: tb/tb_hamming_decode_scheduler.sv
// Bench for hamming_decode_scheduler: a scoreboard fed from observed capture
// handshakes (expected result from a brute-force nearest-codeword search) and
// drained on output handshakes, plus directed arbitration, backpressure,
// counter and reset checks. A second instance runs fixed priority.
module tb_hamming_decode_scheduler;

    typedef struct packed {
        logic [3:0] data;
        logic       chan;
        logic [2:0] syn;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [6:0] req0_code = '0, req1_code = '0;
    logic       req0_odd = 1'b0, req1_odd = 1'b0;
    logic       out_ready = 1'b1;
    logic       cnt_clr = 1'b0;
    logic       req0_ready, req1_ready, out_valid, out_chan, out_err;
    logic [3:0] out_data;
    logic [2:0] out_syndrome;
    logic [7:0] err_cnt0, err_cnt1;

    logic       fp_req0_ready, fp_req1_ready, fp_out_valid, fp_out_chan, fp_out_err;
    logic [3:0] fp_out_data;
    logic [2:0] fp_out_syndrome;
    logic [7:0] fp_err_cnt0, fp_err_cnt1;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    logic grants[$];
    logic fp_grants[$];
    int   exp_cnt0 = 0, exp_cnt1 = 0;
    logic clr_seen = 1'b0;

    hamming_decode_scheduler #(.CNT_W(8), .FAIR(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_code(req0_code),
        .req0_odd(req0_odd),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_code(req1_code),
        .req1_odd(req1_odd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_chan(out_chan), .out_syndrome(out_syndrome), .out_err(out_err),
        .cnt_clr(cnt_clr), .err_cnt0(err_cnt0), .err_cnt1(err_cnt1)
    );

    hamming_decode_scheduler #(.CNT_W(8), .FAIR(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_code(req0_code),
        .req0_odd(req0_odd),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_code(req1_code),
        .req1_odd(req1_odd),
        .out_valid(fp_out_valid), .out_ready(1'b1), .out_data(fp_out_data),
        .out_chan(fp_out_chan), .out_syndrome(fp_out_syndrome), .out_err(fp_out_err),
        .cnt_clr(cnt_clr), .err_cnt0(fp_err_cnt0), .err_cnt1(fp_err_cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] encode(input logic [3:0] d, input logic odd);
        logic [6:0] x;
        x    = '0;
        x[6] = d[3];
        x[5] = d[2];
        x[4] = d[1];
        x[2] = d[0];
        x[0] = x[2] ^ x[4] ^ x[6] ^ odd;
        x[1] = x[2] ^ x[5] ^ x[6] ^ odd;
        x[3] = x[4] ^ x[5] ^ x[6] ^ odd;
        return x;
    endfunction

    // Nearest valid codeword: try no flip, then each single-bit flip
    function automatic exp_t model(input logic [6:0] code, input logic odd, input logic ch);
        exp_t       r;
        logic [6:0] y;
        logic [3:0] d;
        logic       found;
        r     = '0;
        found = 1'b0;
        for (int p = 0; p < 8; p++) begin
            y = code;
            if (p > 0) y[p-1] = ~y[p-1];
            d = {y[6], y[5], y[4], y[2]};
            if (!found && encode(d, odd) == y) begin
                found  = 1'b1;
                r.data = d;
                r.syn  = 3'(p);
                r.err  = (p != 0);
            end
        end
        r.chan = ch;
        return r;
    endfunction

    // Capture monitor: push expected result on every accepted codeword
    always @(negedge clk) begin
        if (rst_n) begin
            if (req0_valid && req0_ready) begin
                sb.push_back(model(req0_code, req0_odd, 1'b0));
                grants.push_back(1'b0);
            end
            if (req1_valid && req1_ready) begin
                sb.push_back(model(req1_code, req1_odd, 1'b1));
                grants.push_back(1'b1);
            end
            if (req0_valid && fp_req0_ready) fp_grants.push_back(1'b0);
            if (req1_valid && fp_req1_ready) fp_grants.push_back(1'b1);
        end
    end

    // Output monitor: pop and compare on every output handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_out", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("out_data", 32'(out_data), 32'(e.data));
                check("out_chan", 32'(out_chan), 32'(e.chan));
                check("out_syndrome", 32'(out_syndrome), 32'(e.syn));
                check("out_err", 32'(out_err), 32'(e.err));
                if (clr_seen) begin
                    exp_cnt0 = 0;
                    exp_cnt1 = 0;
                    clr_seen = 1'b0;
                end else if (e.err) begin
                    if (!e.chan && exp_cnt0 < 255) exp_cnt0++;
                    if (e.chan && exp_cnt1 < 255) exp_cnt1++;
                end
                check("err_cnt0", 32'(err_cnt0), 32'(exp_cnt0));
                check("err_cnt1", 32'(err_cnt1), 32'(exp_cnt1));
            end
        end
    end

    task automatic drive(input logic ch, input logic [6:0] code, input logic odd);
        if (ch) begin
            req1_code = code; req1_odd = odd; req1_valid = 1'b1;
        end else begin
            req0_code = code; req0_odd = odd; req0_valid = 1'b1;
        end
    endtask

    // Wait for the grant, hold valid through the accept edge, then release
    task automatic wait_ready(input logic ch);
        int   i;
        logic seen;
        seen = 1'b0;
        i    = 0;
        while (!seen && i < 60) begin
            @(negedge clk);
            seen = ch ? req1_ready : req0_ready;
            i++;
        end
        if (!seen) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (ch) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic send(input logic ch, input logic [6:0] code, input logic odd);
        drive(ch, code, odd);
        wait_ready(ch);
    endtask

    task automatic wait_out();
        int i;
        i = 0;
        @(negedge clk);
        while (!out_valid && i < 40) begin
            @(negedge clk);
            i++;
        end
        if (!out_valid) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((sb.size() != 0 || out_valid) && i < 80) begin
            @(negedge clk);
            i++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        check("rst_out_fields", 32'({out_data, out_chan, out_syndrome, out_err}), 32'd0);
        check("rst_cnts", 32'({err_cnt0, err_cnt1}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Both channels request continuously: alternate vs. fixed priority
        drive(1'b0, 7'h55, 1'b0);
        drive(1'b1, 7'h45, 1'b0);
        begin
            int i;
            i = 0;
            while (grants.size() < 6 && i < 100) begin
                @(negedge clk);
                i++;
            end
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();
        check("rr_grant_count", 32'(grants.size()), 32'd6);
        for (int i = 0; i < 6 && i < grants.size(); i++)
            check($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % 2));
        check("fp_grant_count", 32'(fp_grants.size()), 32'd6);
        for (int i = 0; i < 6 && i < fp_grants.size(); i++)
            check($sformatf("fp_grant%0d", i), 32'(fp_grants[i]), 32'd0);

        // Clean ch0 even codeword with latency check
        drive(1'b0, 7'h55, 1'b0);
        wait_ready(1'b0);
        @(negedge clk);
        check("lat_decode_cycle", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_out_cycle", 32'(out_valid), 32'd1);
        check("clean_data", 32'(out_data), 32'hB);
        drain();

        // Single-bit errors and odd parity
        send(1'b1, 7'h45, 1'b0);
        drain();
        send(1'b0, 7'h5E, 1'b1);
        drain();
        send(1'b0, 7'h5C, 1'b1);
        drain();
        send(1'b1, 7'h35, 1'b0);   // two-bit error: miscorrected, still counted
        drain();

        // Backpressure: result held, no new grant until handshake
        out_ready = 1'b0;
        send(1'b1, 7'h45, 1'b0);
        drive(1'b0, 7'h55, 1'b0);
        wait_out();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'hB);
            check("bp_syn", 32'(out_syndrome), 32'd5);
            check("bp_chan", 32'(out_chan), 32'd1);
            check("bp_ready", 32'({req0_ready, req1_ready}), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_ready(1'b0);
        drain();

        // Saturation of the ch0 counter
        for (int i = 0; i < 260; i++) begin
            send(1'b0, 7'h54, 1'b0);
            drain();
        end
        check("cnt0_saturated", 32'(err_cnt0), 32'd255);

        // Clear coincident with an increment
        drive(1'b0, 7'h54, 1'b0);
        wait_ready(1'b0);
        cnt_clr  = 1'b1;
        clr_seen = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        drain();
        check("cnt_after_clr", 32'({err_cnt0, err_cnt1}), 32'd0);

        // Asynchronous reset while holding a result in OUT
        out_ready = 1'b0;
        send(1'b0, 7'h45, 1'b0);
        wait_out();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_data", 32'(out_data), 32'd0);
        check("async_rst_cnt0", 32'(err_cnt0), 32'd0);
        sb.delete();
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(1'b1, 7'h45, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
